// File: rtl/ecc_ram_port.sv
// SECDED-protected single-port memory responder: pipelined writes with error injection,
// pipelined reads with single-error correction and double-error detection.
module ecc_ram_port #(
  parameter int A_W   = 4,
  parameter int D_W   = 8,
  parameter int W_LAT = 3,
  parameter int R_LAT = 3,
  // Smallest P with 2**P >= D_W+P+1
  localparam int P_W  = (D_W <= 1)  ? 2 :
                        (D_W <= 4)  ? 3 :
                        (D_W <= 11) ? 4 :
                        (D_W <= 26) ? 5 :
                        (D_W <= 57) ? 6 :
                        (D_W <= 120) ? 7 : 8,
  localparam int CW_W = D_W + P_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [A_W-1:0]  addr,
  input  logic [D_W-1:0]  din,
  input  logic [CW_W-1:0] inj_mask,
  output logic [D_W-1:0]  dout,
  output logic            rd_valid,
  output logic            error,
  output logic            err_dbl
);

  localparam int DEPTH = 2 ** A_W;

  // Data bits occupy every non-power-of-two position >= 3, lowest data bit first.
  function automatic logic [CW_W-1:0] encode(input logic [D_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic            par;
    int              k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k = k + 1;
      end
    end
    for (int i = 0; i < P_W; i++) begin
      par = 1'b0;
      for (int p = 1; p < CW_W; p++) begin
        if (((p >> i) & 1) != 0) par = par ^ cw[p];
      end
      cw[1 << i] = par;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [D_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [D_W-1:0] d;
    int             k;
    d = '0;
    k = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p];
        k = k + 1;
      end
    end
    return d;
  endfunction

  function automatic logic [P_W-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [P_W-1:0] s;
    s = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (cw[p]) s = s ^ P_W'(p);
    end
    return s;
  endfunction

  logic [CW_W-1:0] mem_q     [DEPTH];
  logic            wr_vld_q  [W_LAT];
  logic [A_W-1:0]  wr_addr_q [W_LAT];
  logic [CW_W-1:0] wr_cw_q   [W_LAT];
  logic            rd_vld_q  [R_LAT];
  logic [CW_W-1:0] rd_cw_q   [R_LAT];

  logic [D_W-1:0]  dout_q, dout_d;
  logic            rd_valid_q;
  logic            error_q, error_d;
  logic            err_dbl_q, err_dbl_d;

  logic [CW_W-1:0] cw_raw, cw_fix;
  logic [P_W-1:0]  syn;
  logic            gpar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_q[0]  <= 1'b0;
      wr_addr_q[0] <= '0;
      wr_cw_q[0]   <= '0;
      rd_vld_q[0]  <= 1'b0;
      rd_cw_q[0]   <= '0;
    end else begin
      wr_vld_q[0]  <= en & we;
      wr_addr_q[0] <= addr;
      wr_cw_q[0]   <= encode(din) ^ inj_mask;
      rd_vld_q[0]  <= en & ~we;
      // Sampled before this edge's commit lands, so a same-edge write is not seen.
      rd_cw_q[0]   <= mem_q[addr];
    end
  end

  for (genvar gi = 1; gi < W_LAT; gi++) begin : g_wr_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_vld_q[gi]  <= 1'b0;
        wr_addr_q[gi] <= '0;
        wr_cw_q[gi]   <= '0;
      end else begin
        wr_vld_q[gi]  <= wr_vld_q[gi-1];
        wr_addr_q[gi] <= wr_addr_q[gi-1];
        wr_cw_q[gi]   <= wr_cw_q[gi-1];
      end
    end
  end

  for (genvar gi = 1; gi < R_LAT; gi++) begin : g_rd_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_vld_q[gi] <= 1'b0;
        rd_cw_q[gi]  <= '0;
      end else begin
        rd_vld_q[gi] <= rd_vld_q[gi-1];
        rd_cw_q[gi]  <= rd_cw_q[gi-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_vld_q[W_LAT-1]) begin
      mem_q[wr_addr_q[W_LAT-1]] <= wr_cw_q[W_LAT-1];
    end
  end

  always_comb begin
    cw_raw    = rd_cw_q[R_LAT-1];
    syn       = syndrome(cw_raw);
    gpar      = ^cw_raw;
    cw_fix    = cw_raw;
    error_d   = 1'b0;
    err_dbl_d = 1'b0;
    if (syn == '0) begin
      error_d = gpar;
    end else if (gpar && (int'(syn) < CW_W)) begin
      cw_fix  = cw_raw ^ (CW_W'(1) << syn);
      error_d = 1'b1;
    end else begin
      // Even-weight error, or a syndrome pointing past the codeword: uncorrectable.
      error_d   = 1'b1;
      err_dbl_d = 1'b1;
    end
    dout_d = extract(cw_fix);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
      error_q    <= 1'b0;
      err_dbl_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_vld_q[R_LAT-1];
      if (rd_vld_q[R_LAT-1]) begin
        dout_q    <= dout_d;
        error_q   <= error_d;
        err_dbl_q <= err_dbl_d;
      end
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign error    = error_q;
  assign err_dbl  = err_dbl_q;

endmodule

// File: tb/tb_ecc_ram_port.sv
// Directed bench for ecc_ram_port: reads push expected results into a scoreboard,
// a monitor pops and checks each rd_valid pulse (data, flags, arrival cycle) and output hold.
module tb_ecc_ram_port;

  localparam int R_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [7:0]  din = '0;
  logic [12:0] inj_mask = '0;
  logic [7:0]  dout;
  logic        rd_valid;
  logic        error;
  logic        err_dbl;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       db;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  ecc_ram_port #(.A_W(4), .D_W(8), .W_LAT(3), .R_LAT(R_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .inj_mask(inj_mask), .dout(dout), .rd_valid(rd_valid), .error(error), .err_dbl(err_dbl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; we = 1'b0; inj_mask = '0;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [12:0] m);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; din = d; inj_mask = m;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] d, input logic e, input logic db,
                    input string name);
    exp_t it;
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a; inj_mask = '0;
    it.d = d; it.e = e; it.db = db; it.name = name;
    it.cyc = cyc + 1 + R_LAT;
    sb.push_back(it);
    $display("[TB] issue read %s addr=%0h expect dout=%02h err=%0b dbl=%0b", name, a, d, e, db);
  endtask

  // Monitor: checks each rd_valid pulse against the scoreboard and the hold behaviour between pulses.
  initial begin : monitor
    exp_t       it;
    logic [7:0] last_d;
    logic       last_e;
    logic       last_db;
    last_d = '0; last_e = 1'b0; last_db = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_d = '0; last_e = 1'b0; last_db = 1'b0;
      end else if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          it = sb.pop_front();
          chk({it.name, "_dout"}, 32'(dout), 32'(it.d));
          chk({it.name, "_error"}, 32'(error), 32'(it.e));
          chk({it.name, "_err_dbl"}, 32'(err_dbl), 32'(it.db));
          chk({it.name, "_cycle"}, 32'(cyc), 32'(it.cyc));
          $display("[TB] read %s dout=%02h err=%0b dbl=%0b cyc=%0d", it.name, dout, error, err_dbl, cyc);
          last_d = it.d; last_e = it.e; last_db = it.db;
        end
      end else begin
        chk("hold_dout", 32'(dout), 32'(last_d));
        chk("hold_error", 32'(error), 32'(last_e));
        chk("hold_err_dbl", 32'(err_dbl), 32'(last_db));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached, %0d reads outstanding", sb.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_err_dbl", 32'(err_dbl), 32'd0);

    // No forwarding; a read on the commit edge still sees the old word.
    wr(4'd5, 8'h3C, 13'h0);
    rd(4'd5, 8'h00, 1'b0, 1'b0, "t4_nofwd");
    idle(1);
    rd(4'd5, 8'h00, 1'b0, 1'b0, "t4_same_edge");
    rd(4'd5, 8'h3C, 1'b0, 1'b0, "t4_after");
    idle(6);

    wr(4'd3, 8'hA5, 13'h0);
    idle(3);
    rd(4'd3, 8'hA5, 1'b0, 1'b0, "t1_clean");
    idle(6);

    // Single errors: data position 6, overall parity bit, check bits at 2 and 8.
    wr(4'd3, 8'hA5, 13'h0040);
    idle(3);
    rd(4'd3, 8'hA5, 1'b1, 1'b0, "t2_single_data");
    wr(4'd3, 8'hA5, 13'h0001);
    idle(3);
    rd(4'd3, 8'hA5, 1'b1, 1'b0, "t2_overall");
    wr(4'd4, 8'h5B, 13'h0004);
    idle(3);
    rd(4'd4, 8'h5B, 1'b1, 1'b0, "t2_check_bit2");
    wr(4'd4, 8'hC3, 13'h0100);
    idle(3);
    rd(4'd4, 8'hC3, 1'b1, 1'b0, "t2_check_bit8");
    idle(6);

    // Double errors. Positions 1,2 are check bits, so the raw data field is still 3C.
    wr(4'd7, 8'h3C, 13'h0006);
    idle(3);
    rd(4'd7, 8'h3C, 1'b1, 1'b1, "t3_dbl_check");
    // Positions 3,5 carry data bits 0,1: raw data 3C^03.
    wr(4'd7, 8'h3C, 13'h0028);
    idle(3);
    rd(4'd7, 8'h3F, 1'b1, 1'b1, "t3_dbl_data");
    // Positions 1,2,12: syndrome 15 is off the codeword; position 12 is data bit 7.
    wr(4'd8, 8'hA5, 13'h1006);
    idle(3);
    rd(4'd8, 8'h25, 1'b1, 1'b1, "t3_syn_range");
    idle(8);

    for (int i = 0; i < 16; i++) wr(4'(i), 8'(i) ^ 8'h5A, 13'h0);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'(i) ^ 8'h5A, 1'b0, 1'b0, $sformatf("t5_rd%0d", i));
    idle(8);

    // Reset one cycle after a read issue discards it and the in-flight write.
    wr(4'd9, 8'h77, 13'h0);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = 4'd9;
    @(negedge clk);
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    chk("t6_dout", 32'(dout), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_err_dbl", 32'(err_dbl), 32'd0);
    rd(4'd9, 8'h00, 1'b0, 1'b0, "t6_rd9");
    rd(4'd3, 8'h00, 1'b0, 1'b0, "t6_rd3");
    idle(8);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
